// File: rtl/wb_select_stage.sv
// Write-back result selector: picks one of NSRC sources, formats RISC-V loads,
// and hands the result out through a registered valid/ready stage with a skid entry.
module wb_select_stage #(
    parameter  int XLEN     = 32,
    parameter  int NSRC     = 4,
    parameter  int LOAD_SRC = 0,
    localparam int SELW     = $clog2(NSRC + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NSRC*XLEN-1:0] in_src,
    input  logic [SELW-1:0]      in_sel,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic [4:0]           in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_data,
    output logic [4:0]           out_rd,
    output logic                 out_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   main_data_q, main_data_d;
    logic [4:0]        main_rd_q,   main_rd_d;
    logic              main_err_q,  main_err_d;
    logic [XLEN-1:0]   skid_data_q, skid_data_d;
    logic [4:0]        skid_rd_q,   skid_rd_d;
    logic              skid_err_q,  skid_err_d;

    logic [XLEN-1:0]   sel_word;
    logic [XLEN-1:0]   ld_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   fmt_data;
    logic              fmt_err;
    logic              acc_in, acc_out;

    // Source mux and load formatting, done before capture so both entries hold final values.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SELW'(k))
                sel_word = in_src[k*XLEN +: XLEN];
        end
        ld_word  = in_src[LOAD_SRC*XLEN +: XLEN];
        ld_byte  = ld_word[{in_addr_lo, 3'b000} +: 8];
        ld_half  = in_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        fmt_data = sel_word;
        fmt_err  = 1'b0;
        if (in_sel == SELW'(LOAD_SRC)) begin
            fmt_data = '0;
            case (in_funct3)
                3'b000: fmt_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
                3'b100: fmt_data = {{(XLEN-8){1'b0}}, ld_byte};
                3'b001, 3'b101: begin
                    if (in_addr_lo[0])
                        fmt_err = 1'b1;
                    else if (in_funct3[2])
                        fmt_data = {{(XLEN-16){1'b0}}, ld_half};
                    else
                        fmt_data = {{(XLEN-16){ld_half[15]}}, ld_half};
                end
                3'b010: begin
                    if (in_addr_lo != 2'b00)
                        fmt_err = 1'b1;
                    else
                        fmt_data = ld_word;
                end
                default: fmt_err = 1'b1;
            endcase
        end
    end

    // in_ready looks only at registered state and rst, never at out_ready.
    assign in_ready  = !rst && (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_rd    = main_rd_q;
    assign out_err   = main_err_q;

    assign acc_in  = in_valid && in_ready;
    assign acc_out = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (acc_in) begin
                    state_d     = ONE;
                    main_data_d = fmt_data;
                    main_rd_d   = in_rd;
                    main_err_d  = fmt_err;
                end
            end
            ONE: begin
                if (acc_in && acc_out) begin
                    main_data_d = fmt_data;
                    main_rd_d   = in_rd;
                    main_err_d  = fmt_err;
                end else if (acc_in) begin
                    state_d     = TWO;
                    skid_data_d = fmt_data;
                    skid_rd_d   = in_rd;
                    skid_err_d  = fmt_err;
                end else if (acc_out) begin
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                if (acc_out) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_rd_d   = skid_rd_q;
                    main_err_d  = skid_err_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_rd_q   <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Registered, parametrised write-back result selector for the RISC-V datapath. It picks one of NSRC result sources, such as load data, ALU result or PC+4, by a select code. When the load source is picked, it applies RISC-V byte/halfword/word extraction with sign or zero extension. The result goes out through a one-cycle valid/ready pipeline stage with a two-entry skid buffer, so the stage sits between the memory stage and the register-file write port.

## Interface
- XLEN, 32: datapath width; the design supports XLEN = 32 only.
- NSRC, 4: number of result sources, minimum 2.
- LOAD_SRC, 0: index of the source that carries raw memory read data.
- SELW, $clog2(NSRC+1): select width (derived; not overridden).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage can accept a beat.
- in_src  in  NSRC*XLEN  source k occupies bits [k*XLEN +: XLEN].
- in_sel  in  SELW  source select.
- in_funct3  in  3  load size/sign (RISC-V funct3); used only when in_sel == LOAD_SRC.
- in_addr_lo  in  2  byte offset of the load address.
- in_rd  in  5  destination register, passed through.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  XLEN  selected/formatted result.
- out_rd  out  5  destination register of the beat.
- out_err  out  1  beat carries a misaligned or illegal load.

## Operation
- Select:
  - in_sel = k < NSRC selects source k.
  - in_sel >= NSRC yields result 0 with out_err 0.
- Load formatting applies when in_sel == LOAD_SRC. Memory word is little-endian; byte n = bits [8n+7:8n].
  - 000 LB: byte[addr_lo], sign-extended.
  - 100 LBU: byte[addr_lo], zero-extended.
  - 001 LH: halfword at addr_lo[1] (addr_lo must be even), sign-extended.
  - 101 LHU: same, zero-extended.
  - 010 LW: full word; addr_lo must be 00.
- Error case: a misaligned LH/LHU/LW, or funct3 of 011, 110 or 111, gives result 0 and out_err 1.
- in_funct3 and in_addr_lo are ignored for non-load selects.
- Transfer rules:
  - An input beat transfers when in_valid && in_ready on a rising edge.
  - An output beat transfers when out_valid && out_ready.
- Storage: output register (main) plus one skid entry. Formatting happens before capture, so both entries hold final values.
- State: EMPTY (no beat held), ONE (main full, skid empty), TWO (main and skid full).
  - EMPTY: input beat -> ONE.
  - ONE: input without output -> TWO; output without input -> EMPTY; both -> stay ONE, new beat in main.
  - TWO: output transfer -> ONE, skid moves to main. No input is accepted.
- Signal derivation:
  - in_ready = !rst && state != TWO.
  - out_valid = state != EMPTY.
- Ordering is strictly FIFO. No beat is lost or duplicated.

## Timing
- Reset, on the first clk edge with rst high: state EMPTY, out_valid 0, out_data 0, out_rd 0, out_err 0, skid contents 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-operation discards both held beats. An input presented during reset is not accepted.
- Latency: a beat accepted at edge t appears on out_* from edge t with out_valid high in cycle t+1. It is combinationally independent of in_*.
- Throughput: one beat per cycle while out_ready stays high.
- Hold rule: while out_valid && !out_ready, out_data, out_rd and out_err hold stable.
- Timing isolation: in_ready depends only on registered state, with no combinational path from out_ready.
- Backpressure: after out_ready falls with state ONE, one more beat is accepted. in_ready drops in the following cycle.
- Simultaneous accept and emit in ONE keeps occupancy constant. In TWO, simultaneous in_valid is stalled because in_ready is 0.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_err=0, in_ready=0 throughout; in_ready=1 in the cycle after rst falls; the beat is accepted only then.
- Plain select, with src0..3 = 0x1,0x2,0x3,0x4 and out_ready=1:
  - sel=2 -> out_data=0x3, one cycle after accept.
  - sel=1 -> 0x2.
  - sel=4 -> 0x0, out_err=0.
  - sel=7 -> 0x0, out_err=0.
- Load extension, src0=0x8081F0FF, sel=0:
  - LB addr 1 -> 0xFFFFFFF0.
  - LBU addr 3 -> 0x00000080.
  - LH addr 2 -> 0xFFFF8081.
  - LHU addr 0 -> 0x0000F0FF.
  - LW addr 0 -> 0x8081F0FF.
- Errors, sel=0:
  - LW addr 2 -> out_data=0, out_err=1.
  - LH addr 1 -> out_err=1.
  - funct3=011 -> out_err=1.
  - sel=1 with funct3=011 -> out_err=0.
- Backpressure: send rd=1..6 back-to-back, out_ready low for cycles 2-5 -> in_ready low after the second held beat; out_* stable while stalled; all six rd values emerge once each, in order.
- Mid-stream reset: fill to TWO, pulse rst one cycle -> out_valid=0 next cycle, held beats never emitted, a fresh beat after reset appears with latency 1.
